// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data request and memory handshake bundle for mem_port_arbiter
// slave is the arbiter's view; master is the pipeline/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          IReq;
  logic [AW-1:0] IAddr;
  logic          IValid;
  logic [DW-1:0] IRData;
  logic          IStall;

  logic          DReq;
  logic          DWe;
  logic [AW-1:0] DAddr;
  logic [DW-1:0] DWData;
  logic          DValid;
  logic [DW-1:0] DRData;
  logic          DStall;

  logic          MemReq;
  logic          MemWe;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData;
  logic          MemAck;
  logic [DW-1:0] MemRData;
  logic          MemErr;

  modport slave (
    input  IReq, IAddr, DReq, DWe, DAddr, DWData, MemAck, MemRData,
    output IValid, IRData, IStall, DValid, DRData, DStall,
           MemReq, MemWe, MemAddr, MemWData, MemErr
  );

  modport master (
    output IReq, IAddr, DReq, DWe, DAddr, DWData, MemAck, MemRData,
    input  IValid, IRData, IStall, DValid, DRData, DStall,
           MemReq, MemWe, MemAddr, MemWData, MemErr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
// Optional MemAck timeout abort is enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input logic              CLK,
  input logic              RSTN,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t state;

  assign bus.IStall = bus.IReq & ~bus.IValid;
  assign bus.DStall = bus.DReq & ~bus.DValid;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 2);

  logic [CW-1:0] toCnt;
  logic [CW-1:0] toCntNext;
  logic          toAbort;

  // toCntNext is the number of BUSY cycles elapsed including the current one
  assign toCntNext = toCnt + CW'(1);
  assign toAbort   = (state != IDLE) && !bus.MemAck && (toCntNext == CW'(TIMEOUT));
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state        <= IDLE;
      bus.MemReq   <= 1'b0;
      bus.MemWe    <= 1'b0;
      bus.MemAddr  <= '0;
      bus.MemWData <= '0;
      bus.IValid   <= 1'b0;
      bus.DValid   <= 1'b0;
      bus.IRData   <= '0;
      bus.DRData   <= '0;
      bus.MemErr   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      toCnt        <= '0;
`endif
    end else begin
      bus.IValid <= 1'b0;
      bus.DValid <= 1'b0;
      bus.MemErr <= 1'b0;
      case (state)
        IDLE: begin
          // A requester still showing its Valid pulse is dropping Req; skip it
          if (bus.DReq && !bus.DValid) begin
            bus.MemReq   <= 1'b1;
            bus.MemWe    <= bus.DWe;
            bus.MemAddr  <= bus.DAddr;
            bus.MemWData <= bus.DWData;
            state        <= DBUSY;
          end else if (bus.IReq && !bus.IValid) begin
            bus.MemReq  <= 1'b1;
            bus.MemWe   <= 1'b0;
            bus.MemAddr <= bus.IAddr;
            state       <= IBUSY;
          end
`ifdef MEM_TIMEOUT_EN
          toCnt <= '0;
`endif
        end
        IBUSY, DBUSY: begin
          if (bus.MemAck) begin
            bus.MemReq <= 1'b0;
            bus.MemWe  <= 1'b0;
            if (state == IBUSY) begin
              bus.IRData <= bus.MemRData;
              bus.IValid <= 1'b1;
            end else begin
              if (!bus.MemWe) begin
                bus.DRData <= bus.MemRData;
              end
              bus.DValid <= 1'b1;
            end
            state <= IDLE;
`ifdef MEM_TIMEOUT_EN
            toCnt <= '0;
          end else if (toAbort) begin
            bus.MemReq <= 1'b0;
            bus.MemWe  <= 1'b0;
            bus.MemErr <= 1'b1;
            if (state == IBUSY) begin
              bus.IRData <= '0;
              bus.IValid <= 1'b1;
            end else begin
              bus.DRData <= '0;
              bus.DValid <= 1'b1;
            end
            state <= IDLE;
            toCnt <= '0;
          end else begin
            toCnt <= toCntNext;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic CLK;
  logic RSTN;
  int   total;
  int   bad;
  logic [31:0] expDR;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RSTN = 1'b0;
    bus.IReq = 1'b0; bus.IAddr = '0;
    bus.DReq = 1'b0; bus.DWe = 1'b0; bus.DAddr = '0; bus.DWData = '0;
    bus.MemAck = 1'b0; bus.MemRData = '0;
    tick(); tick();
    total++;
    if ({bus.MemReq, bus.MemWe, bus.IValid, bus.DValid, bus.MemErr} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {bus.MemReq, bus.MemWe, bus.IValid, bus.DValid, bus.MemErr});
    end
    total++;
    if ({bus.MemAddr, bus.MemWData, bus.IRData, bus.DRData} !== 128'h0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0",
               {bus.MemAddr, bus.MemWData, bus.IRData, bus.DRData});
    end
    RSTN = 1'b1;
    tick();
    expDR = 32'h0;
  endtask

  task automatic test_fetch;
    bus.IReq = 1'b1; bus.IAddr = 32'h10;
    tick();
    total++;
    if ({bus.MemReq, bus.MemWe, bus.IStall} !== 3'b101 || bus.MemAddr !== 32'h10) begin
      bad++;
      $display("FAIL fetch_grant got=req%b we%b stall%b addr%h want=req1 we0 stall1 addr10",
               bus.MemReq, bus.MemWe, bus.IStall, bus.MemAddr);
    end
    tick();
    total++;
    if ({bus.MemReq, bus.MemWe, bus.IValid} !== 3'b100) begin
      bad++;
      $display("FAIL fetch_wait got=%b want=100", {bus.MemReq, bus.MemWe, bus.IValid});
    end
    bus.MemAck = 1'b1; bus.MemRData = 32'hA5A5;
    tick();
    total++;
    if ({bus.IValid, bus.MemReq, bus.MemWe, bus.IStall} !== 4'b1000 || bus.IRData !== 32'hA5A5) begin
      bad++;
      $display("FAIL fetch_done got=valid%b req%b we%b stall%b data%h want=valid1 req0 we0 stall0 dataa5a5",
               bus.IValid, bus.MemReq, bus.MemWe, bus.IStall, bus.IRData);
    end
    bus.MemAck = 1'b0; bus.IReq = 1'b0;
    tick();
    total++;
    if ({bus.IValid, bus.MemReq} !== 2'b00) begin
      bad++;
      $display("FAIL fetch_after got=%b want=00", {bus.IValid, bus.MemReq});
    end
  endtask

  task automatic test_ack_in_idle;
    bus.MemAck = 1'b1; bus.MemRData = 32'hFFFF;
    tick();
    bus.MemAck = 1'b0;
    total++;
    if ({bus.IValid, bus.DValid, bus.MemReq} !== 3'b000 || bus.IRData !== 32'hA5A5) begin
      bad++;
      $display("FAIL idle_ack got=%b ird=%h want=000 ird=a5a5",
               {bus.IValid, bus.DValid, bus.MemReq}, bus.IRData);
    end
  endtask

  task automatic test_back_to_back;
    bus.IReq = 1'b1; bus.IAddr = 32'h40;
    bus.DReq = 1'b1; bus.DWe = 1'b1; bus.DAddr = 32'h20; bus.DWData = 32'h1234;
    tick();
    total++;
    if ({bus.MemReq, bus.MemWe} !== 2'b11 || bus.MemAddr !== 32'h20 || bus.MemWData !== 32'h1234) begin
      bad++;
      $display("FAIL b2b_store_grant got=req%b we%b addr%h wd%h want=req1 we1 addr20 wd1234",
               bus.MemReq, bus.MemWe, bus.MemAddr, bus.MemWData);
    end
    total++;
    if ({bus.IStall, bus.DStall} !== 2'b11) begin
      bad++;
      $display("FAIL b2b_stalls got=%b want=11", {bus.IStall, bus.DStall});
    end
    bus.MemAck = 1'b1; bus.MemRData = 32'hDEAD;
    tick();
    total++;
    if ({bus.DValid, bus.MemReq, bus.DStall} !== 3'b100 || bus.DRData !== expDR) begin
      bad++;
      $display("FAIL b2b_store_done got=valid%b req%b dstall%b drd%h want=valid1 req0 dstall0 drd%h",
               bus.DValid, bus.MemReq, bus.DStall, bus.DRData, expDR);
    end
    // DReq deliberately still high across this edge
    bus.MemAck = 1'b0;
    tick();
    bus.DReq = 1'b0;
    total++;
    if ({bus.MemReq, bus.MemWe, bus.DValid} !== 3'b100 || bus.MemAddr !== 32'h40) begin
      bad++;
      $display("FAIL b2b_fetch_grant got=req%b we%b dvalid%b addr%h want=req1 we0 dvalid0 addr40",
               bus.MemReq, bus.MemWe, bus.DValid, bus.MemAddr);
    end
    tick();
    total++;
    if (bus.MemAddr !== 32'h40 || bus.MemReq !== 1'b1) begin
      bad++;
      $display("FAIL b2b_no_reissue got=addr%h req%b want=addr40 req1", bus.MemAddr, bus.MemReq);
    end
    bus.MemAck = 1'b1; bus.MemRData = 32'h5A5A;
    tick();
    total++;
    if (bus.IValid !== 1'b1 || bus.IRData !== 32'h5A5A || bus.DValid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_fetch_done got=ivalid%b ird%h dvalid%b want=ivalid1 ird5a5a dvalid0",
               bus.IValid, bus.IRData, bus.DValid);
    end
    bus.MemAck = 1'b0; bus.IReq = 1'b0;
    tick();
    total++;
    if ({bus.MemReq, bus.IValid, bus.DValid} !== 3'b000) begin
      bad++;
      $display("FAIL b2b_idle got=%b want=000", {bus.MemReq, bus.IValid, bus.DValid});
    end
  endtask

  task automatic test_load;
    bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'h30; bus.DWData = 32'h9999;
    tick();
    total++;
    if ({bus.MemReq, bus.MemWe} !== 2'b10 || bus.MemAddr !== 32'h30) begin
      bad++;
      $display("FAIL load_grant got=req%b we%b addr%h want=req1 we0 addr30",
               bus.MemReq, bus.MemWe, bus.MemAddr);
    end
    bus.MemAck = 1'b1; bus.MemRData = 32'h0BAD;
    tick();
    expDR = 32'h0BAD;
    total++;
    if (bus.DValid !== 1'b1 || bus.DRData !== expDR) begin
      bad++;
      $display("FAIL load_done got=valid%b drd%h want=valid1 drd%h", bus.DValid, bus.DRData, expDR);
    end
    bus.MemAck = 1'b0; bus.DReq = 1'b0;
    tick();
  endtask

  task automatic test_timeout;
    int highCycles;
    logic sawErr;
    logic sawValid;
    highCycles = 0; sawErr = 1'b0; sawValid = 1'b0;
    bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'h50;
    tick();
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      if (bus.MemReq !== 1'b1) begin
        sawErr = bus.MemErr; sawValid = bus.DValid;
        break;
      end
      highCycles++;
      tick();
    end
    bus.DReq = 1'b0;
    expDR = 32'h0;
    total++;
    if (highCycles != 15) begin
      bad++;
      $display("FAIL timeout_len got=%0d want=15", highCycles);
    end
    total++;
    if ({sawErr, sawValid} !== 2'b11 || bus.DRData !== expDR) begin
      bad++;
      $display("FAIL timeout_abort got=err%b valid%b drd%h want=err1 valid1 drd0",
               sawErr, sawValid, bus.DRData);
    end
    tick();
    total++;
    if ({bus.MemErr, bus.DValid, bus.MemReq} !== 3'b000) begin
      bad++;
      $display("FAIL timeout_after got=%b want=000", {bus.MemErr, bus.DValid, bus.MemReq});
    end
`else
    for (int i = 0; i < 100; i++) begin
      if (bus.MemReq === 1'b1 && bus.DValid === 1'b0 && bus.MemErr === 1'b0) highCycles++;
      tick();
    end
    total++;
    if (highCycles != 100) begin
      bad++;
      $display("FAIL no_timeout_hold got=%0d want=100", highCycles);
    end
    bus.MemAck = 1'b1; bus.MemRData = 32'h7777;
    tick();
    sawValid = bus.DValid; sawErr = bus.MemErr;
    expDR = 32'h7777;
    bus.MemAck = 1'b0; bus.DReq = 1'b0;
    total++;
    if ({sawValid, sawErr} !== 2'b10 || bus.DRData !== expDR) begin
      bad++;
      $display("FAIL no_timeout_done got=valid%b err%b drd%h want=valid1 err0 drd7777",
               sawValid, sawErr, bus.DRData);
    end
    tick();
`endif
  endtask

  task automatic test_reset_mid;
    int strayValid;
    strayValid = 0;
    bus.DReq = 1'b1; bus.DWe = 1'b1; bus.DAddr = 32'h60; bus.DWData = 32'hCAFE;
    tick(); tick();
    total++;
    if (bus.MemReq !== 1'b1 || bus.MemWe !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_busy got=req%b we%b want=req1 we1", bus.MemReq, bus.MemWe);
    end
    #2;
    RSTN = 1'b0;
    bus.DReq = 1'b0;
    #1;
    total++;
    if ({bus.MemReq, bus.MemWe, bus.DValid, bus.IValid, bus.MemErr} !== 5'b0 ||
        {bus.MemAddr, bus.MemWData, bus.IRData, bus.DRData} !== 128'h0) begin
      bad++;
      $display("FAIL rstmid_clear got=flags%b addr%h wd%h ird%h drd%h want=all0",
               {bus.MemReq, bus.MemWe, bus.DValid, bus.IValid, bus.MemErr},
               bus.MemAddr, bus.MemWData, bus.IRData, bus.DRData);
    end
    tick();
    RSTN = 1'b1;
    bus.MemAck = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.DValid !== 1'b0 || bus.MemReq !== 1'b0) strayValid++;
    end
    bus.MemAck = 1'b0;
    total++;
    if (strayValid != 0) begin
      bad++;
      $display("FAIL rstmid_no_valid got=%0d want=0", strayValid);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    expDR = 32'h0;
    test_reset();
    test_fetch();
    test_ack_in_idle();
    test_back_to_back();
    test_load();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
